// File: rtl/status_array_reader.sv
// status_array_reader: read-only client of the status array. Issues tagged
// row lookups, buffers tagged responses in an in-order FIFO, decodes per-block
// valid bits and flags out-of-sequence response tags. Credits bound the total
// number of in-flight plus buffered responses, because the array cannot be
// back-pressured.
module status_array_reader #(
  parameter int TAG_WIDTH  = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_BLOCKS = 4,
  parameter int STATUS_W   = 2,
  parameter int VALID_BIT  = 0,
  parameter int DEPTH      = 4,
  parameter int ROW_WIDTH  = NUM_BLOCKS * STATUS_W
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_init_complete,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  output logic [TAG_WIDTH-1:0]  o_sa_tag,
  output logic [ADDR_WIDTH-1:0] o_sa_addr,
  output logic [ROW_WIDTH-1:0]  o_sa_data,
  output logic                  o_sa_wen,
  output logic [NUM_BLOCKS-1:0] o_sa_wmask,
  output logic                  o_sa_valid,
  input  logic                  i_sa_ready,
  input  logic [TAG_WIDTH-1:0]  i_sa_tag,
  input  logic [ROW_WIDTH-1:0]  i_sa_data,
  input  logic                  i_sa_valid,
  output logic [TAG_WIDTH-1:0]  o_rsp_tag,
  output logic [ROW_WIDTH-1:0]  o_rsp_data,
  output logic [NUM_BLOCKS-1:0] o_rsp_vbits,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_tag_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CRD_W = $clog2(DEPTH + 1);

  // Issue side
  logic                  r_sa_valid;
  logic [ADDR_WIDTH-1:0] r_sa_addr;
  logic [TAG_WIDTH-1:0]  r_sa_tag;
  logic [TAG_WIDTH-1:0]  r_issue_cnt;
  logic [CRD_W-1:0]      r_credits;

  // Response side; pointers carry one extra wrap bit to tell full from empty
  logic [TAG_WIDTH-1:0]                 r_exp_cnt;
  logic                                 r_tag_error;
  logic [PTR_W:0]                       r_wptr;
  logic [PTR_W:0]                       r_rptr;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]      r_mem_tag;
  logic [DEPTH-1:0][ROW_WIDTH-1:0]      r_mem_data;

  logic w_accept;
  logic w_sa_fire;
  logic w_wr;
  logic w_pop;
  logic w_empty;
  logic w_full;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  assign o_req_ready = i_init_complete & ~i_halt & (r_credits < CRD_W'(DEPTH)) &
                       (~r_sa_valid | i_sa_ready);
  assign w_accept  = i_req_valid & o_req_ready;
  assign w_sa_fire = r_sa_valid & i_sa_ready & ~i_halt;
  // Array has no back-pressure: responses land whenever not stalled
  assign w_wr      = i_sa_valid & ~i_halt;
  // Pop looks at registered pointers only, so a write never bypasses to the head
  assign w_pop     = ~w_empty & i_rsp_ready & ~i_halt;

  assign o_sa_valid = r_sa_valid;
  assign o_sa_addr  = r_sa_addr;
  assign o_sa_tag   = r_sa_tag;
  assign o_sa_data  = '0;
  assign o_sa_wen   = 1'b0;
  assign o_sa_wmask = '0;

  assign o_rsp_valid = ~w_empty;
  assign o_rsp_tag   = r_mem_tag[r_rptr[PTR_W-1:0]];
  assign o_rsp_data  = r_mem_data[r_rptr[PTR_W-1:0]];
  assign o_tag_error = r_tag_error;

  // Valid flag of each block pulled out of the head row
  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_vbits
    assign o_rsp_vbits[b] = o_rsp_data[b*STATUS_W + VALID_BIT];
  end

  // Request register toward the array: load on accept, drop once taken
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sa_valid  <= 1'b0;
      r_sa_addr   <= '0;
      r_sa_tag    <= '0;
      r_issue_cnt <= '0;
    end else if (w_accept) begin
      r_sa_valid  <= 1'b1;
      r_sa_addr   <= i_req_addr;
      r_sa_tag    <= r_issue_cnt;
      r_issue_cnt <= r_issue_cnt + 1'b1;
    end else if (w_sa_fire) begin
      r_sa_valid  <= 1'b0;
    end
  end

  // Credits: one per accepted request, returned when its response is popped
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_credits <= '0;
    end else if (w_accept && !w_pop) begin
      r_credits <= r_credits + 1'b1;
    end else if (!w_accept && w_pop) begin
      r_credits <= r_credits - 1'b1;
    end
  end

  // Response FIFO storage, write pointer and sticky tag-sequence check
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mem_tag   <= '0;
      r_mem_data  <= '0;
      r_wptr      <= '0;
      r_exp_cnt   <= '0;
      r_tag_error <= 1'b0;
    end else if (w_wr) begin
      r_mem_tag[r_wptr[PTR_W-1:0]]  <= i_sa_tag;
      r_mem_data[r_wptr[PTR_W-1:0]] <= i_sa_data;
      r_wptr    <= r_wptr + 1'b1;
      r_exp_cnt <= r_exp_cnt + 1'b1;
      if (i_sa_tag != r_exp_cnt) r_tag_error <= 1'b1;
    end
  end

  // Read pointer advances on pop
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rptr <= '0;
    end else if (w_pop) begin
      r_rptr <= r_rptr + 1'b1;
    end
  end

  // Credits should make overflow impossible; catch a misbehaving array
  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n) !(w_wr && w_full));

endmodule

// File: tb/tb_status_array_reader.sv
module tb_status_array_reader;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       i_halt, i_init_complete;
  logic [5:0] i_req_addr;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [1:0] o_sa_tag;
  logic [5:0] o_sa_addr;
  logic [7:0] o_sa_data;
  logic       o_sa_wen;
  logic [3:0] o_sa_wmask;
  logic       o_sa_valid;
  logic       i_sa_ready;
  logic [1:0] i_sa_tag;
  logic [7:0] i_sa_data;
  logic       i_sa_valid;
  logic [1:0] o_rsp_tag;
  logic [7:0] o_rsp_data;
  logic [3:0] o_rsp_vbits;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic       o_tag_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  status_array_reader dut (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt), .i_init_complete(i_init_complete),
    .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .o_sa_tag(o_sa_tag), .o_sa_addr(o_sa_addr), .o_sa_data(o_sa_data),
    .o_sa_wen(o_sa_wen), .o_sa_wmask(o_sa_wmask), .o_sa_valid(o_sa_valid),
    .i_sa_ready(i_sa_ready), .i_sa_tag(i_sa_tag), .i_sa_data(i_sa_data),
    .i_sa_valid(i_sa_valid), .o_rsp_tag(o_rsp_tag), .o_rsp_data(o_rsp_data),
    .o_rsp_vbits(o_rsp_vbits), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_tag_error(o_tag_error)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    i_halt = 1'b0; i_req_valid = 1'b0; i_req_addr = '0;
    i_sa_valid = 1'b0; i_sa_tag = '0; i_sa_data = '0; i_rsp_ready = 1'b0;
    #3;
    @(negedge clk);
    arst_n = 1'b1;
    tick();
  endtask

  // One request / response / pop round trip with per-stage checks
  task automatic do_txn(input logic [5:0] addr, input logic [1:0] exp_sa_tag,
                        input logic [1:0] rtag, input logic [7:0] data,
                        input logic exp_err);
    i_req_valid = 1'b1; i_req_addr = addr;
    settle(); chk("txn_req_ready", 32'(o_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0;
    settle();
    chk("txn_sa_valid", 32'(o_sa_valid), 32'd1);
    chk("txn_sa_tag",   32'(o_sa_tag),   32'(exp_sa_tag));
    chk("txn_sa_addr",  32'(o_sa_addr),  32'(addr));
    tick();
    i_sa_valid = 1'b1; i_sa_tag = rtag; i_sa_data = data;
    tick();
    i_sa_valid = 1'b0;
    settle();
    chk("txn_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("txn_rsp_tag",   32'(o_rsp_tag),   32'(rtag));
    chk("txn_rsp_data",  32'(o_rsp_data),  32'(data));
    chk("txn_tag_error", 32'(o_tag_error), 32'(exp_err));
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    settle();
    chk("txn_rsp_empty", 32'(o_rsp_valid), 32'd0);
  endtask

  initial begin
    // ---- Reset with init incomplete and a pending request
    arst_n = 1'b0; i_halt = 1'b0; i_init_complete = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 6'd5; i_sa_ready = 1'b1;
    i_sa_valid = 1'b0; i_sa_tag = '0; i_sa_data = '0; i_rsp_ready = 1'b0;
    #3;
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    chk("rst_sa_valid",  32'(o_sa_valid),  32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(o_rsp_data),  32'd0);
    chk("rst_tag_error", 32'(o_tag_error), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    tick(); tick();
    settle();
    chk("noinit_req_ready", 32'(o_req_ready), 32'd0);
    chk("noinit_sa_valid",  32'(o_sa_valid),  32'd0);
    chk("tied_wr", {o_sa_data, o_sa_wmask, 3'b000, o_sa_wen}, 32'd0);

    // ---- First lookup, response written while a pop is asserted on empty FIFO
    i_init_complete = 1'b1;
    settle();
    chk("init_req_ready", 32'(o_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0;
    settle();
    chk("first_sa_valid", 32'(o_sa_valid), 32'd1);
    chk("first_sa_addr",  32'(o_sa_addr),  32'd5);
    chk("first_sa_tag",   32'(o_sa_tag),   32'd0);
    tick();
    settle();
    chk("first_sa_drop",  32'(o_sa_valid), 32'd0);
    i_sa_valid = 1'b1; i_sa_tag = 2'd0; i_sa_data = 8'b01_00_01_01; i_rsp_ready = 1'b1;
    settle();
    chk("nobypass_empty", 32'(o_rsp_valid), 32'd0);
    tick();
    i_sa_valid = 1'b0;
    settle();
    chk("first_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("first_vbits",     32'(o_rsp_vbits), 32'b1011);
    chk("first_rsp_tag",   32'(o_rsp_tag),   32'd0);
    tick();
    i_rsp_ready = 1'b0;
    settle();
    chk("first_popped", 32'(o_rsp_valid), 32'd0);

    // ---- Five back-to-back requests, no pops: credits stop the fifth
    for (int k = 0; k < 5; k++) begin
      i_req_valid = 1'b1; i_req_addr = 6'(20 + k);
      settle();
      chk($sformatf("b2b_ready%0d", k), 32'(o_req_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
      if (k < 4) begin
        settle();
        chk($sformatf("b2b_tag%0d", k), 32'(o_sa_tag), 32'((1 + k) % 4));
        chk($sformatf("b2b_addr%0d", k), 32'(o_sa_addr), 32'(20 + k));
      end
    end
    settle();
    chk("b2b_sa_drained", 32'(o_sa_valid), 32'd0);
    for (int j = 0; j < 4; j++) begin
      i_sa_valid = 1'b1; i_sa_tag = 2'((1 + j) % 4); i_sa_data = 8'(j);
      tick();
    end
    i_sa_valid = 1'b0;
    settle();
    chk("full_req_ready", 32'(o_req_ready), 32'd0);
    chk("full_head_tag",  32'(o_rsp_tag),   32'd1);
    i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    settle();
    chk("credit_back_ready", 32'(o_req_ready), 32'd1);
    for (int j = 1; j < 4; j++) begin
      chk($sformatf("drain_tag%0d", j), 32'(o_rsp_tag), 32'((1 + j) % 4));
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      settle();
    end
    chk("drain_empty",     32'(o_rsp_valid), 32'd0);
    chk("drain_tag_error", 32'(o_tag_error), 32'd0);

    // ---- Tag wrap: six transactions from a fresh reset
    do_reset();
    for (int i = 0; i < 6; i++)
      do_txn(6'(i), 2'(i % 4), 2'(i % 4), 8'(i * 17), 1'b0);

    // ---- Out-of-sequence tag is sticky
    do_reset();
    do_txn(6'd1, 2'd0, 2'd0, 8'hAA, 1'b0);
    do_txn(6'd2, 2'd1, 2'd2, 8'hBB, 1'b1);
    do_txn(6'd3, 2'd2, 2'd2, 8'hCC, 1'b1);

    // ---- Halt mid-burst with a response presented
    do_reset();
    i_req_valid = 1'b1; i_req_addr = 6'd10;
    tick();
    i_req_addr = 6'd11;
    i_sa_valid = 1'b1; i_sa_tag = 2'd0; i_sa_data = 8'h3C;
    tick();
    i_req_addr = 6'd12; i_halt = 1'b1;
    i_sa_tag = 2'd1; i_sa_data = 8'h5A; i_rsp_ready = 1'b1;
    settle();
    chk("halt_req_ready", 32'(o_req_ready), 32'd0);
    for (int h = 0; h < 3; h++) begin
      tick();
      settle();
      chk($sformatf("halt_sa_valid%0d", h), 32'(o_sa_valid),  32'd1);
      chk($sformatf("halt_sa_tag%0d", h),   32'(o_sa_tag),    32'd1);
      chk($sformatf("halt_sa_addr%0d", h),  32'(o_sa_addr),   32'd11);
      chk($sformatf("halt_rsp_tag%0d", h),  32'(o_rsp_tag),   32'd0);
      chk($sformatf("halt_rsp_data%0d", h), 32'(o_rsp_data),  32'h3C);
      chk($sformatf("halt_rsp_vld%0d", h),  32'(o_rsp_valid), 32'd1);
    end
    i_halt = 1'b0; i_req_valid = 1'b0;
    tick();
    i_sa_valid = 1'b0;
    settle();
    chk("resume_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("resume_rsp_tag",   32'(o_rsp_tag),   32'd1);
    chk("resume_rsp_data",  32'(o_rsp_data),  32'h5A);
    chk("resume_sa_valid",  32'(o_sa_valid),  32'd0);
    tick();
    i_rsp_ready = 1'b0;
    settle();
    chk("resume_empty",     32'(o_rsp_valid), 32'd0);
    chk("resume_tag_error", 32'(o_tag_error), 32'd0);
    chk("resume_ready",     32'(o_req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
